// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: samples hSync/vSync/bright on pixel ticks,
// measures line/frame timing, recovers pixel coordinates and tracks lock.
module vga_sync_monitor #(
    parameter int H_TS        = 800,
    parameter int H_TPW       = 96,
    parameter int V_TS        = 521,
    parameter int V_TPW       = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk50MHz,
    input  logic       clr,
    input  logic       pixEn,
    input  logic       hSyncIn,
    input  logic       vSyncIn,
    input  logic       brightIn,
    output logic [9:0] xPos,
    output logic [9:0] yPos,
    output logic       pixValid,
    output logic [9:0] measLineLen,
    output logic [9:0] measHPulse,
    output logic [9:0] measFrameLines,
    output logic [9:0] measVPulse,
    output logic       locked,
    output logic       timingErr
);

    localparam logic [9:0] CNT_MAX = 10'h3FF;
    localparam logic [9:0] H_TS_W  = 10'(H_TS);
    localparam logic [9:0] H_TPW_W = 10'(H_TPW);
    localparam logic [9:0] V_TS_W  = 10'(V_TS);
    localparam logic [9:0] V_TPW_W = 10'(V_TPW);
    localparam int         GW      = $clog2(LOCK_FRAMES + 1) + 1;
    localparam logic [GW-1:0] LOCK_N = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] goodCnt, good_d, goodInc;

    logic       hPrev, vPrev;
    logic [9:0] hCnt, hLow, lCnt, vLow;
    logic       firstLine, frameOk;

    logic       hFall, hRise, vFall, vRise, bRise, bFall;
    logic [9:0] lineLenNow;
    logic       lineBad, hwBad, vwBad, frameLenBad, hLost, frameGood, errPulse;

    // pixValid doubles as the previous bright sample
    assign hFall = pixEn &  hPrev    & ~hSyncIn;
    assign hRise = pixEn & ~hPrev    &  hSyncIn;
    assign vFall = pixEn &  vPrev    & ~vSyncIn;
    assign vRise = pixEn & ~vPrev    &  vSyncIn;
    assign bRise = ~pixValid &  brightIn;
    assign bFall =  pixValid & ~brightIn;

    assign lineLenNow  = (hCnt == CNT_MAX) ? CNT_MAX : hCnt + 10'd1;
    assign lineBad     = hFall & ~firstLine & (lineLenNow != H_TS_W);
    assign hwBad       = hRise & (hLow != H_TPW_W);
    assign vwBad       = vRise & (vLow != V_TPW_W);
    assign frameLenBad = vFall & (lCnt != V_TS_W);
    // hCnt stepping into saturation means hSync has gone missing
    assign hLost       = pixEn & ~hFall & (hCnt == CNT_MAX - 10'd1);
    assign frameGood   = frameOk & ~lineBad & ~hwBad & ~vwBad & ~frameLenBad;
    assign goodInc     = goodCnt + 1'b1;

    always_comb begin
        state_d  = state_q;
        good_d   = goodCnt;
        errPulse = 1'b0;
        case (state_q)
            SEARCH: begin
                if (vFall) begin
                    state_d = TRAIN;
                    good_d  = '0;
                end
            end
            TRAIN: begin
                if (vFall) begin
                    if (frameGood) begin
                        good_d = goodInc;
                        if (goodInc >= LOCK_N) state_d = LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (lineBad | hwBad | vwBad | frameLenBad | hLost) begin
                    errPulse = 1'b1;
                    state_d  = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk50MHz or negedge clr) begin
        if (!clr) begin
            state_q   <= SEARCH;
            goodCnt   <= '0;
            locked    <= 1'b0;
            timingErr <= 1'b0;
        end else begin
            state_q   <= state_d;
            goodCnt   <= good_d;
            locked    <= (state_d == LOCKED);
            timingErr <= errPulse;
        end
    end

    always_ff @(posedge clk50MHz or negedge clr) begin
        if (!clr) begin
            hPrev          <= 1'b1;
            vPrev          <= 1'b1;
            pixValid       <= 1'b0;
            hCnt           <= '0;
            hLow           <= '0;
            lCnt           <= '0;
            vLow           <= '0;
            firstLine      <= 1'b1;
            frameOk        <= 1'b0;
            measLineLen    <= '0;
            measHPulse     <= '0;
            measFrameLines <= '0;
            measVPulse     <= '0;
            xPos           <= '0;
            yPos           <= '0;
        end else if (pixEn) begin
            hPrev    <= hSyncIn;
            vPrev    <= vSyncIn;
            pixValid <= brightIn;

            if (hFall) begin
                hCnt      <= '0;
                firstLine <= 1'b0;
                if (!firstLine) measLineLen <= lineLenNow;
            end else if (hCnt != CNT_MAX) begin
                hCnt <= hCnt + 10'd1;
            end

            if (hRise) begin
                measHPulse <= hLow;
                hLow       <= '0;
            end else if (!hSyncIn && hLow != CNT_MAX) begin
                hLow <= hLow + 10'd1;
            end

            // a line starting together with vSync belongs to the new frame
            if (vFall) begin
                measFrameLines <= lCnt;
                lCnt           <= hFall ? 10'd1 : 10'd0;
            end else if (hFall && lCnt != CNT_MAX) begin
                lCnt <= lCnt + 10'd1;
            end

            if (vRise) begin
                measVPulse <= vLow;
                vLow       <= '0;
            end else if (hFall && !vSyncIn && vLow != CNT_MAX) begin
                vLow <= vLow + 10'd1;
            end

            if (vFall)                          frameOk <= 1'b1;
            else if (lineBad | hwBad | vwBad)   frameOk <= 1'b0;

            if (bRise)         xPos <= '0;
            else if (brightIn) xPos <= xPos + 10'd1;

            if (vFall)      yPos <= '0;
            else if (bFall) yPos <= yPos + 10'd1;
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Randomized self-checking bench for vga_sync_monitor on a shrunken raster
// (20x10 ticks, 8x4 active) with random pixEn gaps and junk between ticks.
module tb_vga_sync_monitor;

    localparam int H_TS = 20, H_TPW = 3, V_TS = 10, V_TPW = 2, LOCK_FRAMES = 2;
    localparam int AX0 = 6, AXN = 8, AY0 = 4, AYN = 4;

    logic       clk50MHz = 1'b0;
    logic       clr = 1'b1, pixEn = 1'b0;
    logic       hSyncIn = 1'b1, vSyncIn = 1'b1, brightIn = 1'b0;
    logic [9:0] xPos, yPos, measLineLen, measHPulse, measFrameLines, measVPulse;
    logic       pixValid, locked, timingErr;

    vga_sync_monitor #(
        .H_TS(H_TS), .H_TPW(H_TPW), .V_TS(V_TS), .V_TPW(V_TPW), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk50MHz(clk50MHz), .clr(clr), .pixEn(pixEn),
        .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .brightIn(brightIn),
        .xPos(xPos), .yPos(yPos), .pixValid(pixValid),
        .measLineLen(measLineLen), .measHPulse(measHPulse),
        .measFrameLines(measFrameLines), .measVPulse(measVPulse),
        .locked(locked), .timingErr(timingErr)
    );

    always #10 clk50MHz = ~clk50MHz;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference state: previous samples, ticks since hSync fell, lock bookkeeping
    bit m_h, m_v, m_b, m_first, m_ok, e_lock, e_err, last_err, rst_req;
    int m_acc, m_low, m_lines, m_vlow, m_mode, m_run;
    int e_line, e_hp, e_fl, e_vp, e_x, e_y, vfall_n;
    bit ev_hf, ev_hr, ev_vf, ev_vr;
    int g_col, g_row;
    bit obs_prev_lock;
    int obs_lock_at, obs_err_vf;

    task automatic model_reset();
        m_h = 1; m_v = 1; m_b = 0; m_first = 1; m_ok = 0;
        m_acc = 0; m_low = 0; m_lines = 0; m_vlow = 0; m_mode = 0; m_run = 0;
        e_line = 0; e_hp = 0; e_fl = 0; e_vp = 0; e_x = 0; e_y = 0;
        e_lock = 0; e_err = 0; last_err = 0; vfall_n = 0;
        obs_prev_lock = 0; obs_lock_at = -1; obs_err_vf = -1;
    endtask

    task automatic model_step(input bit h, input bit v, input bit b);
        int  len;
        bit  bad, lost;
        ev_hf = m_h & !h;  ev_hr = !m_h & h;
        ev_vf = m_v & !v;  ev_vr = !m_v & v;
        len  = (m_acc + 1 > 1023) ? 1023 : m_acc + 1;
        bad  = (ev_hf && !m_first && len != H_TS) || (ev_hr && m_low != H_TPW) ||
               (ev_vr && m_vlow != V_TPW) || (ev_vf && m_lines != V_TS);
        lost = !ev_hf && m_acc == 1022;
        e_err = 0;
        if (m_mode == 2) begin
            if (bad || lost) begin e_err = 1; m_mode = 0; end
        end else if (ev_vf) begin
            if (m_mode == 0) begin
                m_mode = 1; m_run = 0;
            end else begin
                m_run = (m_ok && !bad) ? m_run + 1 : 0;
                if (m_run >= LOCK_FRAMES) m_mode = 2;
            end
        end
        e_lock = (m_mode == 2);
        if (ev_vf) vfall_n++;
        if (ev_hf) begin
            if (!m_first) e_line = len;
            m_first = 0; m_acc = 0;
        end else if (m_acc < 1023) m_acc++;
        if (ev_hr) begin e_hp = m_low; m_low = 0; end
        else if (!h && m_low < 1023) m_low++;
        if (ev_vf) begin e_fl = m_lines; m_lines = ev_hf ? 1 : 0; end
        else if (ev_hf && m_lines < 1023) m_lines++;
        if (ev_vr) begin e_vp = m_vlow; m_vlow = 0; end
        else if (ev_hf && !v && m_vlow < 1023) m_vlow++;
        if (ev_vf) m_ok = 1;
        else if (bad) m_ok = 0;
        if (b && !m_b) e_x = 0;
        else if (b) e_x++;
        if (ev_vf) e_y = 0;
        else if (!b && m_b) e_y++;
        m_h = h; m_v = v; m_b = b;
    endtask

    task automatic pix_tick(input bit h, input bit v, input bit b);
        @(negedge clk50MHz);
        if (last_err) chk("err_width", 64'(timingErr), 64'(0));
        pixEn = 1; hSyncIn = h; vSyncIn = v; brightIn = b;
        @(negedge clk50MHz);
        pixEn = 0; {hSyncIn, vSyncIn, brightIn} = 3'($urandom);
        model_step(h, v, b);
        chk("locked", 64'(locked), 64'(e_lock));
        chk("timingErr", 64'(timingErr), 64'(e_err));
        chk("pixValid", 64'(pixValid), 64'(b));
        if (b) begin
            chk("xPos", 64'(xPos), 64'(e_x));
            chk("yPos", 64'(yPos), 64'(e_y));
            chk("x_geom", 64'(xPos), 64'(g_col - AX0));
            chk("y_geom", 64'(yPos), 64'(g_row - AY0));
        end
        if (ev_hf) chk("measLineLen", 64'(measLineLen), 64'(e_line));
        if (ev_hr) chk("measHPulse", 64'(measHPulse), 64'(e_hp));
        if (ev_vf) chk("measFrameLines", 64'(measFrameLines), 64'(e_fl));
        if (ev_vr) chk("measVPulse", 64'(measVPulse), 64'(e_vp));
        last_err = e_err;
        if (locked && !obs_prev_lock) obs_lock_at = vfall_n;
        obs_prev_lock = locked;
        if (timingErr) obs_err_vf = vfall_n;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk50MHz);
            {hSyncIn, vSyncIn, brightIn} = 3'($urandom);
        end
        if (rst_req) begin
            rst_req = 0;
            #3 clr = 0;
            #1 chk("async_rst", {xPos, yPos, pixValid, measLineLen, measHPulse,
                                 measFrameLines, measVPulse, locked, timingErr}, 64'(0));
            model_reset();
            @(negedge clk50MHz);
            clr = 1;
        end
    endtask

    task automatic send_frame(input int nlines, input int vpw, input int bad_line,
                              input int bad_len, input int bad_hpw, input int rst_line);
        int len, hpw, vc;
        bit b;
        vc = 0;
        for (int line = 0; line < nlines; line++) begin
            len = (line == bad_line) ? bad_len : H_TS;
            hpw = (line == bad_line) ? bad_hpw : H_TPW;
            for (int col = 0; col < len; col++) begin
                b = (line >= AY0) && (line < AY0 + AYN) && (col >= AX0) && (col < AX0 + AXN);
                if (line == rst_line && col == 10) rst_req = 1;
                g_col = col; g_row = line;
                pix_tick(!(col < hpw), !(line < vpw), b);
                if (pixValid) vc++;
                if (line == bad_line && hpw == 0 && col == len - 1) begin
                    chk("hold_meas_kept", 64'(measLineLen), 64'(H_TS));
                    chk("hold_unlocked", 64'(locked), 64'(0));
                end
            end
        end
        if (rst_line < 0) chk("valid_cnt", 64'(vc), 64'(AXN * AYN));
    endtask

    task automatic nominal(input int n);
        repeat (n) send_frame(V_TS, V_TPW, -1, 0, 0, -1);
    endtask

    initial begin
        int vf0;
        model_reset();
        rst_req = 0;
        #1 clr = 0;
        repeat (3) @(negedge clk50MHz);
        chk("reset_state", {xPos, yPos, pixValid, measLineLen, measHPulse,
                            measFrameLines, measVPulse, locked, timingErr}, 64'(0));
        clr = 1;

        // lock acquisition on nominal timing
        nominal(4);
        chk("lock_at_vfall", 64'(obs_lock_at), 64'(3));
        chk("nom_line", 64'(measLineLen), 64'(H_TS));
        chk("nom_hpulse", 64'(measHPulse), 64'(H_TPW));
        chk("nom_frame", 64'(measFrameLines), 64'(V_TS));
        chk("nom_vpulse", 64'(measVPulse), 64'(V_TPW));

        // one stretched line while locked, then relock
        obs_lock_at = -1; obs_err_vf = -1;
        send_frame(V_TS, V_TPW, 5, H_TS + 1, H_TPW, -1);
        chk("stretch_err_seen", 64'(obs_err_vf >= 0), 64'(1));
        nominal(4);
        chk("relock_gap", 64'(obs_lock_at - obs_err_vf), 64'(3));

        // short frame while training
        send_frame(V_TS, V_TPW, 5, H_TS + 1, H_TPW, -1);
        nominal(1);
        vf0 = vfall_n;
        obs_lock_at = -1;
        send_frame(V_TS - 1, V_TPW, -1, 0, 0, -1);
        nominal(3);
        chk("train_bad_lock", 64'(obs_lock_at), 64'(vf0 + 4));

        // hSync held high while locked
        obs_err_vf = -1;
        send_frame(V_TS, V_TPW, 8, 1100, 0, -1);
        chk("hold_err_seen", 64'(obs_err_vf >= 0), 64'(1));
        nominal(3);

        // randomized timing variations
        repeat (8)
            send_frame($urandom_range(V_TS - 1, V_TS + 1), $urandom_range(1, 3),
                       $urandom_range(0, 8), $urandom_range(H_TS - 1, H_TS + 1),
                       $urandom_range(2, 4), -1);

        // asynchronous reset mid-line, then relock from scratch
        nominal(1);
        send_frame(V_TS, V_TPW, -1, 0, 0, 3);
        nominal(4);
        chk("post_rst_lock", 64'(obs_lock_at), 64'(3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_600_000;
        errors++;
        $display("FAIL watchdog timeout checks %0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side checker for the VGA raster interface: samples hSync/vSync/bright, measures line and frame timing, recovers pixel coordinates, and reports lock/error status.
- Sits on the sink side of the timing generator, used by capture and overlay logic and by on-board self-test.
- Runs in the 50 MHz domain; samples only on the 25 MHz pixel enable.

Parameters:
- H_TS, 800, expected pixel ticks between consecutive hSync falling edges
- H_TPW, 96, expected hSync low width in ticks
- V_TS, 521, expected lines (hSync falling edges) between vSync falling edges
- V_TPW, 2, expected vSync low width in lines
- LOCK_FRAMES, 2, consecutive good frames required to assert locked

Ports:
- clk50MHz, in, 1, system clock
- clr, in, 1, reset; asynchronous, active-low
- pixEn, in, 1, pixel-tick enable (25 MHz, one clk50MHz cycle in two); all sampling and counting only when 1
- hSyncIn, in, 1, horizontal sync, active-low pulse
- vSyncIn, in, 1, vertical sync, active-low pulse
- brightIn, in, 1, active-video flag
- xPos, out, 10, column of current active pixel
- yPos, out, 10, row of current active pixel
- pixValid, out, 1, xPos/yPos valid this tick
- measLineLen, out, 10, last measured line length
- measHPulse, out, 10, last measured hSync low width
- measFrameLines, out, 10, last measured frame length in lines
- measVPulse, out, 10, last measured vSync low width in lines
- locked, out, 1, timing matches parameters
- timingErr, out, 1, one-clk50MHz-cycle pulse when lock is lost

Behaviour:
- Reset (clr=0, async): all outputs 0; sample registers (hPrev, vPrev) set to 1; FSM state SEARCH; all counters 0; firstLine=1.
- Sampling: on pixEn ticks, inputs are registered. Edges are detected against the previous sample. hFall = prev 1, now 0; hRise = prev 0, now 1. vFall is defined the same way.
- Line counter hCnt (10b):
  - Cleared to 0 on an hFall tick; otherwise increments and saturates at 1023.
  - On hFall with firstLine=0: measLineLen <= hCnt+1, saturating at 1023 (nominal 800). firstLine is then cleared.
- hSync width: hLow counts ticks with the sample low. On hRise: measHPulse <= hLow (nominal 96), then hLow <= 0.
- Frame line counter lCnt:
  - Increments on each hFall and saturates.
  - On vFall: measFrameLines <= lCnt (nominal 521) and lCnt <= 0.
  - If vFall and hFall occur on the same tick, the line belongs to the new frame: lCnt becomes 1.
- vSync width: vLow counts hFall events while vSync is low. On vRise: measVPulse <= vLow (nominal 2), then vLow <= 0.
- Coordinates:
  - xPos increments on each bright tick and is cleared on the bright rising edge.
  - yPos increments on each bright falling edge and is cleared on vFall.
  - pixValid equals the registered bright sample.
  - Output order: first active pixel gives x=0, y=0; last gives x=639, y=479. Both values update one pixel tick after the input sample.
- frameOk flag:
  - Set at vFall.
  - Cleared on any hFall whose measured line length is not H_TS.
  - Cleared on any hRise whose width is not H_TPW.
  - Cleared on vRise with width not V_TPW.
  - Evaluated with lCnt at the next vFall: the frame is good only if frameOk=1 and lCnt = V_TS.
- FSM:
  - SEARCH: on the first vFall, go to TRAIN with goodCnt=0. This first partial frame is never judged.
  - TRAIN: at each vFall, a good frame increments goodCnt and a bad frame clears it. When goodCnt reaches LOCK_FRAMES, go to LOCKED and set locked=1.
  - LOCKED, error conditions: a line-length mismatch at hFall, an hSync width mismatch at hRise, or a frame-length or vSync-width mismatch. Also hCnt reaching 1023 (loss of hSync).
  - LOCKED, on error: timingErr=1 for exactly one clk50MHz cycle, locked=0, go to SEARCH.
- pixEn=0 for any duration: nothing changes.
- Mid-frame reset: restarts in SEARCH; the partial frame is discarded.

Test Plan:
- Drive nominal 640x480 timing from the timing generator after reset. Required: locked rises at the 3rd vFall. measLineLen=800, measHPulse=96, measFrameLines=521, measVPulse=2.
- Nominal stream, check coordinates. Required: the first pixValid tick of a frame gives xPos=0, yPos=0; the last gives 639, 479; exactly 307200 valid ticks per frame.
- While locked, stretch one line to 801 ticks. Required: timingErr high for one clk50MHz cycle at that hFall, locked=0, state SEARCH. locked returns after 3 further vFalls.
- Hold hSyncIn high while locked. Required: hCnt saturates at 1023, timingErr pulses, locked=0; measLineLen keeps its last value.
- During TRAIN, inject one 520-line frame. Required: goodCnt clears, so lock requires 2 more good frames (locked at the 4th vFall after the bad frame's start).
- Assert clr asynchronously mid-line, between pixEn ticks. Required: all outputs 0 immediately without a clock edge. After release, no measLineLen update on the first hFall (firstLine).
